// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants for the VGA raster timing block: default 640x480@60
// timing, derived line/frame totals, sync window helpers and colour widths.
// The optional frame counter (macro VGA_TIMING_FRAME_CNT_EN) uses
// FRAME_CNT_W from here.

package vga_timing_pkg;

    // Pixel clock divider: 50 MHz system clock down to a 25 MHz pixel rate.
    localparam int CLK_DIV_DEF = 2;
    localparam int CLK_DIV_MAX = 16;

    // Horizontal timing, in pixels.
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    // Vertical timing, in lines.
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // The h/v counters are 10 bits wide, so no total may exceed 1024.
    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1 << CNT_W;

    // Colour widths of the RGB332 path.
    localparam int RED_W   = 3;
    localparam int GREEN_W = 3;
    localparam int BLUE_W  = 2;
    localparam int RGB_W   = RED_W + GREEN_W + BLUE_W;

    localparam int FRAME_CNT_W = 16;

    // Length of a line (or frame) given its four segments.
    function automatic int line_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First counter value inside the sync pulse.
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // Last counter value inside the sync pulse (inclusive).
    function automatic int sync_end(input int active, input int fp,
                                    input int sync);
        return active + fp + sync - 1;
    endfunction

    localparam int H_TOTAL_DEF = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    localparam int HS_START_DEF = sync_start(H_ACTIVE_DEF, H_FP_DEF);
    localparam int HS_END_DEF   = sync_end(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF);
    localparam int VS_START_DEF = sync_start(V_ACTIVE_DEF, V_FP_DEF);
    localparam int VS_END_DEF   = sync_end(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF);

endpackage

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick
// Divides the system clock down to the pixel rate. The count only advances
// while i_en is high, so dropping the enable freezes the raster mid-pixel
// and resuming continues from the same phase.
// CLK_DIV = 1 has no count at all: the tick is simply the enable, delayed
// by one register.

module vga_pixel_tick
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_pixel_tick
);

    if (CLK_DIV < 1 || CLK_DIV > CLK_DIV_MAX) begin : g_div_range_chk
        $error("vga_pixel_tick: CLK_DIV must be in 1..16");
    end

    if (CLK_DIV == 1) begin : g_div1

        logic r_tick;

        // Every enabled clock is a pixel; register it to keep the output glitch-free.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_tick <= 1'b0;
            end else begin
                r_tick <= i_en;
            end
        end

        assign o_pixel_tick = r_tick;

    end else begin : g_divn

        localparam int DIV_W = $clog2(CLK_DIV);
        localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

        logic [DIV_W-1:0] r_cnt;
        logic             w_cnt_last;

        assign w_cnt_last = (r_cnt == DIV_LAST);

        // Modulo-CLK_DIV phase counter, held while the raster is frozen.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt <= '0;
            end else if (i_en) begin
                r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
            end
        end

        // Gate with the enable so a frozen raster never sees a tick.
        assign o_pixel_tick = i_en && w_cnt_last;

    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480@60 VGA raster timing. Owns the h/v pixel counters that define
// every pixel coordinate in the design, decodes active video and the sync
// windows, and registers blanked colour together with the syncs onto the
// connector pins, one pixel period behind the counters.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit free-running
// frame counter output (frame_cnt).

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [RED_W-1:0]   red,
    input  logic [GREEN_W-1:0] green,
    input  logic [BLUE_W-1:0]  blue,
    output logic [CNT_W-1:0]   h,
    output logic [CNT_W-1:0]   v,
    output logic               pixel_tick,
    output logic               video_on,
    output logic               frame_start,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic [RED_W-1:0]   vga_red,
    output logic [GREEN_W-1:0] vga_green,
    output logic [BLUE_W-1:0]  vga_blue
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > CNT_MAX) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL exceeds the 10-bit counter range");
    end

    if (V_TOTAL > CNT_MAX) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL exceeds the 10-bit counter range");
    end

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    logic               w_tick;
    logic [CNT_W-1:0]   r_h;
    logic [CNT_W-1:0]   r_v;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_frame_wrap;
    logic               w_video_on;
    logic               w_hs_raw;
    logic               w_vs_raw;
    logic [RGB_W-1:0]   w_rgb_blanked;
    logic [RGB_W-1:0]   r_rgb;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_frame_start;

    vga_pixel_tick #(
        .CLK_DIV      (CLK_DIV)
    ) u_pixel_tick (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .o_pixel_tick (w_tick)
    );

    assign w_h_last     = (r_h == H_LAST);
    assign w_v_last     = (r_v == V_LAST);
    assign w_frame_wrap = w_tick && w_h_last && w_v_last;

    assign w_video_on = (r_h < H_ACT_END) && (r_v < V_ACT_END);
    assign w_hs_raw   = (r_h >= HS_FIRST) && (r_h <= HS_LAST);
    assign w_vs_raw   = (r_v >= VS_FIRST) && (r_v <= VS_LAST);

    // Colour is forced to black outside the visible area so the monitor
    // sees a clean blanking level during porches and syncs.
    assign w_rgb_blanked = w_video_on ? {red, green, blue} : '0;

    // Raster position: h walks the line, v advances on each line wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Pin stage: syncs and blanked colour sampled from the same h/v on the
    // same tick, so they stay mutually aligned one pixel behind the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= '0;
        end else if (w_tick) begin
            r_hsync <= ~w_hs_raw;
            r_vsync <= ~w_vs_raw;
            r_rgb   <= w_rgb_blanked;
        end
    end

    // One-clock pulse in the first clock of position (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    // Counts frames, stepping on the same edge that raises frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign h           = r_h;
    assign v           = r_v;
    assign pixel_tick  = w_tick;
    assign video_on    = w_video_on;
    assign frame_start = r_frame_start;
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign vga_red     = r_rgb[RGB_W-1 -: RED_W];
    assign vga_green   = r_rgb[BLUE_W +: GREEN_W];
    assign vga_blue    = r_rgb[BLUE_W-1:0];

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing: pixel-rate tick, h/v pixel counters, active-video flag, hsync/vsync.
- Drives the h/v inputs of the pixel/colour generator and receives its red/green/blue back.
- Registers the colour with blanking applied, aligned with the syncs, onto the VGA connector pins.
- Top-level neighbour of the image generator; its counters define every pixel coordinate in the design.

Parameters:
- CLK_DIV, 2: system clocks per pixel (50 MHz -> 25 MHz); legal 1..16.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, pixels.
- H_SYNC, 96: hsync width, pixels.
- H_BP, 48: horizontal back porch, pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, lines.
- V_SYNC, 2: vsync width, lines.
- V_BP, 33: vertical back porch, lines.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  timing enable; low freezes the raster
- red  in  3  colour from the image generator for the current h/v
- green  in  3  colour from the image generator
- blue  in  2  colour from the image generator
- h  out  10  horizontal pixel counter, 0..H_TOTAL-1
- v  out  10  vertical line counter, 0..V_TOTAL-1
- pixel_tick  out  1  one-clk pulse per pixel period
- video_on  out  1  combinational; (h < H_ACTIVE) && (v < V_ACTIVE)
- frame_start  out  1  one-clk pulse on the first clk with h=0, v=0
- vga_hsync  out  1  registered hsync, active low
- vga_vsync  out  1  registered vsync, active low
- vga_red  out  3  registered, blanked colour
- vga_green  out  3  registered, blanked colour
- vga_blue  out  2  registered, blanked colour

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be <= 1024; elaboration fails otherwise.
- Reset values: divider = 0, h = 0, v = 0, pixel_tick = 0, frame_start = 0, vga_hsync = 1, vga_vsync = 1, vga_red/green/blue = 0. video_on reads 1 in reset because it decodes h = v = 0.
- Divider:
  - Counts 0..CLK_DIV-1 while en = 1; pixel_tick is high for the clk in which the count equals CLK_DIV-1.
  - CLK_DIV = 1: pixel_tick = en, registered, so the first tick appears one clk after reset release.
- Counters:
  - On pixel_tick, h increments; at h = H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 with h wrapping, v wraps to 0.
  - h and v change only on a tick.
- Sync decode: hs_raw is true for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751). vs_raw is true for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
- Output stage, updated only on pixel_tick:
  - vga_hsync <= ~hs_raw; vga_vsync <= ~vs_raw.
  - rgb <= video_on ? {red, green, blue} : 0.
  - Fixed latency of one pixel period from h/v to the pins; syncs and colour are always mutually aligned.
- frame_start is registered: high for exactly one clk after the tick that moves (799,524) to (0,0).
- en = 0: the divider holds its count, no ticks occur, and all registers hold their values. Resuming continues mid-pixel with no glitch.
- Reset mid-frame: all state returns to reset values immediately (asynchronous assertion); the raster restarts at (0,0). Deassertion is synchronised to clk by the board reset path.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt [15:0]; reset value 0.
  - Increments by 1 in the same clk in which frame_start is asserted; wraps from 0xFFFF to 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants for 640x480@60;
  - the derived H_TOTAL and V_TOTAL;
  - sync start/end helper constants;
  - colour width constants (3/3/2).
- One sub-module, vga_pixel_tick: the CLK_DIV divider with en input and pixel_tick output.
- Counters, sync decode and output stage stay in vga_timing_gen.

Test Plan:
- Reset, then release with en = 1 and CLK_DIV = 2: pixel_tick every 2nd clk; h counts 0..799 then returns to 0; v increments at that wrap.
- Full frame: vga_hsync low for exactly 96 ticks, first low at pin time h = 657, v = 0. vga_vsync low for 2 lines (1600 ticks), starting at v = 490 (pin-aligned). frame_start pulses once every 420000 ticks.
- Constant red = 7, green = 7, blue = 3 input: vga_* = max for pin pixels 0..639 and 0 from pin pixel 640 onward. Output is 0 on all of lines 480..524.
- Drop en for 37 clks at h = 300: h, v and all outputs hold. After en returns, the h = 300 -> 301 step occurs after the remaining divider count.
- Assert rst_n = 0 at h = 700, v = 491 (syncs low): within the same clk edge window, vga_hsync = vga_vsync = 1, rgb = 0, h = v = 0.
- CLK_DIV = 1 with VGA_TIMING_FRAME_CNT_EN defined: after 3 frames, frame_cnt = 3. Force frame_cnt to 0xFFFF: the next frame_start wraps it to 0.
